// File: rtl/filter_capture_pkg.sv
// Shared types and default sizing for the filter output recorder.
// Holds the recorder FSM state encoding and the default sample width and capture depth.
// Imported by capture_ram and filter_capture.
package filter_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } cap_state_t;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

endpackage

// File: rtl/filter_capture_capture_ram.sv
// capture_ram: simple dual-port sample RAM, one write port and one synchronous read port.
// Latency: read data appears one clock after a cycle with re=1; rdata holds while re=0.
// Ports: clk, write (we/waddr/wdata), read (re/raddr/rdata). No reset; contents undefined at power-up.
module capture_ram
    import filter_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // Gated read enable lets the read register act as a holding stage.
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/filter_capture.sv
// filter_capture: discards `skip` settling samples, captures DEPTH samples, then streams them out.
// Latency: busy rises the cycle after arm; rd_valid rises 2 cycles after READOUT entry, then 1 sample/cycle.
// Ports: clk/rst (sync, active-high), arm/skip, din_valid/din, busy/done, rd_* valid/ready stream.
// Optional: define FILTER_CAPTURE_PEAK_EN to add peak_max/peak_min over captured samples.
module filter_capture
    import filter_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic [15:0]              skip,
    input  logic                     din_valid,
    input  logic signed [DATA_W-1:0] din,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic signed [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_last
`ifdef FILTER_CAPTURE_PEAK_EN
    ,
    output logic signed [DATA_W-1:0] peak_max,
    output logic signed [DATA_W-1:0] peak_min
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    cap_state_t                state;
    logic [15:0]               skip_cnt;
    logic [ADDR_W-1:0]         wr_addr;
    logic [ADDR_W-1:0]         fetch_addr;   // next RAM address to read
    logic                      fetch_done;   // every address has been issued
    logic                      pend;         // RAM read register holds an unconsumed sample
    logic [ADDR_W-1:0]         pend_addr;    // address of the sample in the RAM read register
    logic [DATA_W-1:0]         ram_q;

    logic wr_en;
    logic rd_en;
    logic out_free;
    logic out_fire;

    assign wr_en    = (state == CAPTURE) && din_valid;
    assign out_fire = rd_valid && rd_ready;
    assign out_free = !rd_valid || rd_ready;
    // Only read when the RAM register is empty or is being drained this cycle,
    // so a stalled sample in it is never overwritten.
    assign rd_en    = (state == READOUT) && !fetch_done && (!pend || out_free);

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (din),
        .re    (rd_en),
        .raddr (fetch_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            skip_cnt   <= '0;
            wr_addr    <= '0;
            fetch_addr <= '0;
            fetch_done <= 1'b0;
            pend       <= 1'b0;
            pend_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_addr    <= '0;
            rd_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        skip_cnt   <= skip;
                        wr_addr    <= '0;
                        fetch_addr <= '0;
                        fetch_done <= 1'b0;
                        pend       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= (skip != 16'd0) ? SKIP : CAPTURE;
                    end
                end
                SKIP: begin
                    if (din_valid) begin
                        skip_cnt <= skip_cnt - 16'd1;
                        // The sample that takes the count to zero is still discarded.
                        if (skip_cnt == 16'd1) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (din_valid) begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        if (wr_addr == LAST_ADDR) begin
                            state <= READOUT;
                        end
                    end
                end
                READOUT: begin
                    if (rd_en) begin
                        pend_addr  <= fetch_addr;
                        fetch_addr <= fetch_addr + ADDR_W'(1);
                        if (fetch_addr == LAST_ADDR) begin
                            fetch_done <= 1'b1;
                        end
                    end
                    pend <= rd_en || (pend && !out_free);

                    // Output register refills from the RAM register whenever it is
                    // empty or being accepted, giving one sample per cycle.
                    if (pend && out_free) begin
                        rd_valid <= 1'b1;
                        rd_data  <= ram_q;
                        rd_addr  <= pend_addr;
                        rd_last  <= (pend_addr == LAST_ADDR);
                    end else if (out_fire) begin
                        rd_valid <= 1'b0;
                    end

                    if (out_fire && rd_last) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FILTER_CAPTURE_PEAK_EN
    logic peak_first;   // next captured sample is the first of the run

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_max   <= '0;
            peak_min   <= '0;
            peak_first <= 1'b0;
        end else if (state == IDLE && arm) begin
            peak_first <= 1'b1;
        end else if (wr_en) begin
            peak_first <= 1'b0;
            if (peak_first || din > peak_max) begin
                peak_max <= din;
            end
            if (peak_first || din < peak_min) begin
                peak_min <= din;
            end
        end
    end
`endif

endmodule

// File: tb/tb_filter_capture.sv
// Directed testbench for filter_capture: reset, ramp, skip, gapped/backpressured, signed,
// reset mid-capture, reset+arm collision and ignored arm during readout.
// Inputs are driven and outputs sampled on the falling edge.
module tb_filter_capture;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic                     clk;
    logic                     rst;
    logic                     arm;
    logic [15:0]              skip;
    logic                     din_valid;
    logic signed [DATA_W-1:0] din;
    logic                     busy;
    logic                     done;
    logic                     rd_valid;
    logic                     rd_ready;
    logic signed [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_last;
`ifdef FILTER_CAPTURE_PEAK_EN
    logic signed [DATA_W-1:0] peak_max;
    logic signed [DATA_W-1:0] peak_min;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    filter_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .skip      (skip),
        .din_valid (din_valid),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .rd_last   (rd_last)
`ifdef FILTER_CAPTURE_PEAK_EN
        ,
        .peak_max  (peak_max),
        .peak_min  (peak_min)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // kind 0: ramp base+idx truncated to 12 bits; kind 1: alternating 0x800 / 0x7FF.
    function automatic logic [DATA_W-1:0] exp_val(input int kind, input int base, input int idx);
        if (kind == 0) return DATA_W'(base + idx);
        return (idx % 2 == 0) ? 12'h800 : 12'h7FF;
    endfunction

    task automatic drive(input int kind, input int base, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                din_valid = 1'b0;
                din       = 12'sh5A5;
                @(negedge clk);
            end
            din_valid = 1'b1;
            din       = exp_val(kind, base, i);
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic arm_run(input logic [15:0] s);
        arm  = 1'b1;
        skip = s;
        @(negedge clk);
        arm  = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL arm_busy: busy=%b required 1", busy); end
    endtask

    task automatic read_check(input string name, input int kind, input int base, input bit rnd, input int arm_at);
        int idx = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit rdy;
        logic [DATA_W-1:0] s_data;
        logic [ADDR_W-1:0] s_addr;
        logic              s_last;
        while (idx < DEPTH && cyc < 6000) begin
            if (stalled) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== s_data || rd_addr !== s_addr || rd_last !== s_last) begin
                    n_fail++;
                    $display("FAIL %s_stall: valid=%b data=%h addr=%0d last=%b required 1 %h %0d %b",
                             name, rd_valid, rd_data, rd_addr, rd_last, s_data, s_addr, s_last);
                end
            end
            rdy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready = rdy;
            arm      = (idx == arm_at);
            stalled  = 1'b0;
            if (rd_valid && rdy) begin
                n_checks++;
                if (rd_data !== exp_val(kind, base, idx) || rd_addr !== ADDR_W'(idx) ||
                    rd_last !== (idx == DEPTH - 1)) begin
                    n_fail++;
                    $display("FAIL %s_data[%0d]: data=%h addr=%0d last=%b required %h %0d %b",
                             name, idx, rd_data, rd_addr, rd_last, exp_val(kind, base, idx), idx, idx == DEPTH - 1);
                end
                idx++;
            end else if (rd_valid) begin
                stalled = 1'b1;
                s_data  = rd_data;
                s_addr  = rd_addr;
                s_last  = rd_last;
            end
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b0;
        arm      = 1'b0;
        if (idx < DEPTH) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d samples required %0d", name, idx, DEPTH);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b busy=%b valid=%b required 1 0 0", name, done, busy, rd_valid);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: done=%b required 0", name, done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b valid=%b required 0 0 0", busy, done, rd_valid);
        end
        n_checks++;
        if (rd_last !== 1'b0 || rd_data !== 12'sd0 || rd_addr !== 10'd0) begin
            n_fail++; $display("FAIL reset_data: last=%b data=%h addr=%0d required 0 0 0", rd_last, rd_data, rd_addr);
        end
`ifdef FILTER_CAPTURE_PEAK_EN
        n_checks++;
        if (peak_max !== 12'sd0 || peak_min !== 12'sd0) begin
            n_fail++; $display("FAIL reset_peak: max=%h min=%h required 0 0", peak_max, peak_min);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        arm_run(16'd0);
        drive(0, 0, DEPTH, 1'b0);
        // Now one cycle into READOUT; rd_valid must appear two cycles after entry.
        n_checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ramp_entry: valid=%b busy=%b required 0 1", rd_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_lat1: valid=%b required 0", rd_valid); end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_lat2: valid=%b required 1", rd_valid); end
        read_check("ramp", 0, 0, 1'b0, -1);
    endtask

    task automatic test_skip();
        arm_run(16'd5);
        drive(0, 0, 1031, 1'b0);
        read_check("skip", 0, 5, 1'b0, -1);
    endtask

    task automatic test_gapped();
        arm_run(16'd0);
        drive(0, 100, DEPTH, 1'b1);
        read_check("gapped", 0, 100, 1'b1, -1);
    endtask

    task automatic test_signed();
        arm_run(16'd0);
        drive(1, 0, DEPTH, 1'b0);
        read_check("signed", 1, 0, 1'b0, -1);
`ifdef FILTER_CAPTURE_PEAK_EN
        n_checks++;
        if (peak_min !== -12'sd2048 || peak_max !== 12'sd2047) begin
            n_fail++; $display("FAIL signed_peak: max=%h min=%h required 7ff 800", peak_max, peak_min);
        end
`endif
    endtask

    task automatic test_reset_mid();
        arm_run(16'd0);
        drive(0, 50, 300, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL resetmid_busy: busy=%b valid=%b required 0 0", busy, rd_valid);
        end
        rst = 1'b0;
        arm_run(16'd0);
        drive(0, 0, DEPTH, 1'b0);
        read_check("resetmid", 0, 0, 1'b0, -1);
    endtask

    task automatic test_reset_arm();
        rst  = 1'b1;
        arm  = 1'b1;
        skip = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        arm = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstarm_busy: busy=%b required 0", busy); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstarm_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_ignored_arm();
        arm_run(16'd0);
        drive(0, 7, DEPTH, 1'b0);
        read_check("ignarm", 0, 7, 1'b0, 500);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL ignarm_idle[%0d]: busy=%b done=%b required 0 0", i, busy, done);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        arm       = 1'b0;
        skip      = 16'd0;
        din_valid = 1'b0;
        din       = '0;
        rd_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_ramp();
        test_skip();
        test_gapped();
        test_signed();
        test_reset_mid();
        test_reset_arm();
        test_ignored_arm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
